// File: rtl/sipo_serial_driver.sv
// sipo_serial_driver
// Serialises a byte accepted over a VALID/READY handshake onto the pins of an
// 8-bit right-shifting SIPO shift register (DS, SHCP, STCP, MR_bar, OE_bar).
// Each shift-clock, latch and clear phase lasts CLK_DIV system clocks.
// A CLEAR request pulses MR_bar low and then latches the zeroed register.
// Optional feature macro: SIPO_DRV_MSB_FIRST_EN (send DATA[7] first).
// All outputs are registered; RST is asynchronous and active-high.
module sipo_serial_driver #(
    parameter int CLK_DIV = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] DATA,
    input  logic       VALID,
    output logic       READY,
    input  logic       CLEAR,
    input  logic       OE_REQ,
    output logic       DONE,
    output logic       DS,
    output logic       SHCP,
    output logic       STCP,
    output logic       MR_bar,
    output logic       OE_bar
);

    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        BIT_LO   = 3'd1,
        BIT_HI   = 3'd2,
        LATCH_HI = 3'd3,
        LATCH_LO = 3'd4,
        CLR      = 3'd5
    } state_t;

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic [2:0]    idx_reg;
    logic [6:0]    buf_reg;      // bits still to be sent, next one in bit 0
    logic          ds_reg;
    logic          shcp_reg;
    logic          stcp_reg;
    logic          mr_bar_reg;
    logic          oe_bar_reg;
    logic          ready_reg;
    logic          done_reg;

    logic [7:0]    data_ord;     // DATA rearranged so bit 0 is transmitted first
    logic          phase_end;

`ifdef SIPO_DRV_MSB_FIRST_EN
    for (genvar gi = 0; gi < 8; gi++) begin : g_rev
        assign data_ord[gi] = DATA[7-gi];
    end
`else
    assign data_ord = DATA;
`endif

    assign phase_end = (cnt_reg == DIV_LAST);

    // Output enable simply follows the request, inverted, one clock later
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            oe_bar_reg <= 1'b1;
        end else begin
            oe_bar_reg <= ~OE_REQ;
        end
    end

    // Frame sequencer: phase counter, bit index, shift buffer and pin registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            idx_reg    <= '0;
            buf_reg    <= '0;
            ds_reg     <= 1'b0;
            shcp_reg   <= 1'b0;
            stcp_reg   <= 1'b0;
            mr_bar_reg <= 1'b1;
            ready_reg  <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    cnt_reg    <= '0;
                    ds_reg     <= 1'b0;
                    shcp_reg   <= 1'b0;
                    stcp_reg   <= 1'b0;
                    mr_bar_reg <= 1'b1;
                    ready_reg  <= 1'b1;
                    // READY must already be high for a request to count
                    if (ready_reg && CLEAR) begin
                        state_reg  <= CLR;
                        mr_bar_reg <= 1'b0;
                        ready_reg  <= 1'b0;
                    end else if (ready_reg && VALID) begin
                        state_reg <= BIT_LO;
                        idx_reg   <= '0;
                        ds_reg    <= data_ord[0];
                        buf_reg   <= data_ord[7:1];
                        ready_reg <= 1'b0;
                    end
                end
                BIT_LO: begin
                    if (phase_end) begin
                        cnt_reg   <= '0;
                        shcp_reg  <= 1'b1;
                        state_reg <= BIT_HI;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                BIT_HI: begin
                    if (phase_end) begin
                        cnt_reg  <= '0;
                        shcp_reg <= 1'b0;
                        if (idx_reg == 3'd7) begin
                            // last bit clocked in: drop DS and raise the latch
                            ds_reg    <= 1'b0;
                            stcp_reg  <= 1'b1;
                            state_reg <= LATCH_HI;
                        end else begin
                            idx_reg   <= idx_reg + 1'b1;
                            ds_reg    <= buf_reg[0];
                            buf_reg   <= {1'b0, buf_reg[6:1]};
                            state_reg <= BIT_LO;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                LATCH_HI: begin
                    if (phase_end) begin
                        cnt_reg   <= '0;
                        stcp_reg  <= 1'b0;
                        state_reg <= LATCH_LO;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                LATCH_LO: begin
                    if (phase_end) begin
                        cnt_reg   <= '0;
                        done_reg  <= 1'b1;
                        ready_reg <= 1'b1;
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                CLR: begin
                    if (phase_end) begin
                        // register is already zero; release reset and latch it
                        cnt_reg    <= '0;
                        mr_bar_reg <= 1'b1;
                        stcp_reg   <= 1'b1;
                        state_reg  <= LATCH_HI;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    cnt_reg    <= '0;
                    ds_reg     <= 1'b0;
                    shcp_reg   <= 1'b0;
                    stcp_reg   <= 1'b0;
                    mr_bar_reg <= 1'b1;
                    ready_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign DS     = ds_reg;
    assign SHCP   = shcp_reg;
    assign STCP   = stcp_reg;
    assign MR_bar = mr_bar_reg;
    assign OE_bar = oe_bar_reg;
    assign READY  = ready_reg;
    assign DONE   = done_reg;

endmodule

// File: tb/tb_sipo_serial_driver.sv
// tb_sipo_serial_driver
// Scoreboarded bench: stimulus pushes the expected frame result when a frame
// is accepted; a negedge monitor models the downstream shift register and
// checks each frame when DONE pulses. Honours SIPO_DRV_MSB_FIRST_EN.
module tb_sipo_serial_driver;

    localparam int CLK_DIV = 2;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] DATA = 8'h00;
    logic       VALID = 1'b0;
    logic       CLEAR = 1'b0;
    logic       OE_REQ = 1'b0;
    logic       READY, DONE, DS, SHCP, STCP, MR_bar, OE_bar;

    sipo_serial_driver #(.CLK_DIV(CLK_DIV)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .DATA   (DATA),
        .VALID  (VALID),
        .READY  (READY),
        .CLEAR  (CLEAR),
        .OE_REQ (OE_REQ),
        .DONE   (DONE),
        .DS     (DS),
        .SHCP   (SHCP),
        .STCP   (STCP),
        .MR_bar (MR_bar),
        .OE_bar (OE_bar)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] exp_out;
        logic [7:0] exp_ds;
        int         exp_lat;
        int         exp_shcp;
        int         exp_mr;
        int         acc;
        bit         b2b;
        int         id;
    } frame_t;

    frame_t sb[$];

    // Expected values that depend on bit order
`ifdef SIPO_DRV_MSB_FIRST_EN
    localparam logic [7:0] E01 = 8'h80;
    localparam logic [7:0] E0F = 8'hF0;
`else
    localparam logic [7:0] E01 = 8'h01;
    localparam logic [7:0] E0F = 8'h0F;
`endif

    // Downstream SIPO model and per-frame monitor state
    logic [7:0] sr = 8'h00;
    logic [7:0] out_m = 8'h00;
    logic [7:0] ds_seq = 8'h00;
    logic       prev_shcp = 1'b0, prev_stcp = 1'b0, prev_ds = 1'b0;
    int n_shcp = 0, n_stcp = 0, n_mr = 0, stable = 0, viol = 0, last_rise = 0;
    int last_done = -100;

    initial begin
        forever begin
            @(negedge CLK);
            if (RST) begin
                prev_shcp = 1'b0; prev_stcp = 1'b0; prev_ds = 1'b0;
                n_shcp = 0; n_stcp = 0; n_mr = 0; viol = 0; stable = 0;
                ds_seq = 8'h00;
            end else begin
                if (!MR_bar) begin
                    sr = 8'h00;
                    n_mr++;
                end
                if (DS !== prev_ds) begin
                    if (SHCP && prev_shcp) viol++;
                    stable = 0;
                end else begin
                    stable++;
                end
                if (SHCP && !prev_shcp) begin
                    if (stable < CLK_DIV) viol++;
                    if (n_shcp > 0 && (cyc - last_rise) != 2 * CLK_DIV) viol++;
                    last_rise = cyc;
                    if (n_shcp < 8) ds_seq[n_shcp] = DS;
                    if (MR_bar) sr = {DS, sr[7:1]};
                    n_shcp++;
                end
                if (STCP && !prev_stcp) begin
                    out_m = sr;
                    n_stcp++;
                end
                if (DONE) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        frame_t f;
                        f = sb.pop_front();
                        $display("frame %0d: out=0x%02h ds_seq=0x%02h latency=%0d shcp=%0d stcp=%0d mr_low=%0d",
                                 f.id, out_m, ds_seq, cyc - (f.acc + 1), n_shcp, n_stcp, n_mr);
                        check("latched_out", 32'(out_m), 32'(f.exp_out));
                        check("ds_sequence", 32'(ds_seq), 32'(f.exp_ds));
                        check("done_latency", 32'(cyc - (f.acc + 1)), 32'(f.exp_lat));
                        check("shcp_edges", 32'(n_shcp), 32'(f.exp_shcp));
                        check("stcp_pulses", 32'(n_stcp), 32'd1);
                        check("mr_low_cycles", 32'(n_mr), 32'(f.exp_mr));
                        check("timing_violations", 32'(viol), 32'd0);
                        check("ready_with_done", 32'(READY), 32'd1);
                        if (f.b2b) check("b2b_accept_on_done", 32'(f.acc), 32'(last_done));
                    end
                    last_done = cyc;
                    n_shcp = 0; n_stcp = 0; n_mr = 0; viol = 0; ds_seq = 8'h00;
                end
                prev_shcp = SHCP; prev_stcp = STCP; prev_ds = DS;
            end
        end
    end

    // Offer one frame; returns one clock after acceptance (inputs still held if hold=1)
    task automatic send(input int id, input logic [7:0] d, input bit clr, input bit hold,
                        input bit b2b, input logic [7:0] eo, input logic [7:0] eds);
        frame_t f;
        bit got;
        got = 1'b0;
        @(posedge CLK);
        #1;
        DATA = d; VALID = 1'b1; CLEAR = clr;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge CLK);
            if (READY) begin
                got = 1'b1;
                f.exp_out  = eo;
                f.exp_ds   = eds;
                f.exp_lat  = clr ? 3 * CLK_DIV : 18 * CLK_DIV;
                f.exp_shcp = clr ? 0 : 8;
                f.exp_mr   = clr ? CLK_DIV : 0;
                f.acc      = cyc;
                f.b2b      = b2b;
                f.id       = id;
                sb.push_back(f);
            end
        end
        if (!got) check("accept_timeout", 32'd0, 32'd1);
        @(posedge CLK);
        #1;
        if (!hold) VALID = 1'b0;
        CLEAR = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge CLK);
        check("frame_completion_timeout", 32'(sb.size()), 32'd0);
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // power-up reset
        #2 RST = 1'b1;
        #1;
        check("reset_pins", {25'd0, DS, SHCP, STCP, MR_bar, OE_bar, READY, DONE}, 32'b0001100);
        repeat (2) @(negedge CLK);
        @(posedge CLK);
        #1 RST = 1'b0;
        check("ready_low_after_release", 32'(READY), 32'd0);
        @(posedge CLK);
        #1;
        check("ready_after_one_edge", 32'(READY), 32'd1);

        // single frame, 0x99 (bit pattern is its own reverse)
        send(1, 8'h99, 1'b0, 1'b0, 1'b0, 8'h99, 8'h99);
        wait_idle();

        // back-to-back with VALID held
        send(2, 8'hA5, 1'b0, 1'b1, 1'b0, 8'hA5, 8'hA5);
        send(3, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 8'h3C);
        wait_idle();

        // CLEAR has priority over VALID
        send(4, 8'h77, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        wait_idle();

        // bit-order probe
        send(5, 8'h01, 1'b0, 1'b0, 1'b0, E01, E01);
        wait_idle();

        // reset in the middle of a 0xFF frame
        send(6, 8'hFF, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF);
        for (int i = 0; i < 100 && n_shcp < 3; i++) @(negedge CLK);
        check("third_shcp_seen", 32'(n_shcp >= 3), 32'd1);
        #2 RST = 1'b1;
        #1;
        sb.delete();
        check("midframe_reset_pins", {25'd0, DS, SHCP, STCP, MR_bar, OE_bar, READY, DONE}, 32'b0001100);
        repeat (3) @(negedge CLK);
        check("out_kept_after_reset", 32'(out_m), 32'(E01));
        @(posedge CLK);
        #1 RST = 1'b0;
        @(posedge CLK);
        #1;
        check("ready_after_reset_release", 32'(READY), 32'd1);
        check("out_kept_after_release", 32'(out_m), 32'(E01));

        send(7, 8'h0F, 1'b0, 1'b0, 1'b0, E0F, E0F);
        wait_idle();

        // output enable follows the request with one cycle of latency
        @(posedge CLK);
        #1 OE_REQ = 1'b1;
        @(negedge CLK);
        check("oe_bar_before_edge", 32'(OE_bar), 32'd1);
        @(negedge CLK);
        check("oe_bar_low", 32'(OE_bar), 32'd0);
        @(posedge CLK);
        #1 OE_REQ = 1'b0;
        @(negedge CLK);
        check("oe_bar_hold", 32'(OE_bar), 32'd0);
        @(negedge CLK);
        check("oe_bar_high", 32'(OE_bar), 32'd1);

        check("idle_ready", 32'(READY), 32'd1);
        check("idle_done_low", 32'(DONE), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
